// File: rtl/trainerror_pkg.sv
// Shared definitions for the LTSM TRAINERROR sideband handshake (TX initiator and RX responder).
package trainerror_pkg;

  localparam int TRAINERROR_entry_req_msg  = 15;
  localparam int TRAINERROR_entry_resp_msg = 14;

  localparam int DEFAULT_TIMEOUT_CYCLES = 8000;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    SEND_REQ  = 2'd1,
    WAIT_RESP = 2'd2,
    DONE      = 2'd3
  } te_state_e;

endpackage

// File: rtl/sb_valid_handshake.sv
// Sideband message-valid control: raise when the shared bus is free, defer while the
// local responder owns it, drop when the SB finishes taking the message.
module sb_valid_handshake (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  input  logic start,
  input  logic active,
  input  logic busy,
  input  logic falling_edge_busy,
  input  logic rx_valid,
  output logic valid,
  output logic valid_fall
);

  logic valid_d1;
  logic pending;
  logic raise_now;
  logic raise_pend;

  assign raise_now  = start && !busy && !rx_valid;
  assign raise_pend = pending && active && !rx_valid;
  assign valid_fall = valid_d1 && !valid;

  always_ff @(posedge clk) begin
    if (rst || clear) begin
      valid    <= 1'b0;
      valid_d1 <= 1'b0;
      pending  <= 1'b0;
    end else begin
      valid_d1 <= valid;
      // The SB consuming the message always wins over a new raise.
      if (falling_edge_busy)
        valid <= 1'b0;
      else if (raise_now || raise_pend)
        valid <= 1'b1;

      if (valid)
        pending <= 1'b0;
      else if (start && !(raise_now && !falling_edge_busy))
        pending <= 1'b1;
    end
  end

endmodule

// File: rtl/tx_trainerror_hs.sv
// TRAINERROR entry initiator: sends the entry req on the sideband, waits for the partner's
// entry resp, and reports completion or timeout to the LTSM.
module tx_trainerror_hs
  import trainerror_pkg::*;
#(
  parameter int SB_MSG_WIDTH   = 4,
  parameter int TIMEOUT_CYCLES = DEFAULT_TIMEOUT_CYCLES
) (
  input  logic                    i_clk,
  input  logic                    i_rst,
  input  logic                    i_trainerror_en,
  input  logic                    i_SB_Busy,
  input  logic                    i_falling_edge_busy,
  input  logic                    i_rx_valid,
  input  logic [SB_MSG_WIDTH-1:0] i_decoded_SB_msg,
  output logic [SB_MSG_WIDTH-1:0] o_encoded_SB_msg_tx,
  output logic                    o_valid_tx,
  output logic                    o_trainerror_end_tx,
  output logic                    o_timeout
);

  localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);
  localparam logic [SB_MSG_WIDTH-1:0] REQ_CODE  = SB_MSG_WIDTH'(TRAINERROR_entry_req_msg);
  localparam logic [SB_MSG_WIDTH-1:0] RESP_CODE = SB_MSG_WIDTH'(TRAINERROR_entry_resp_msg);

  te_state_e        state;
  te_state_e        state_next;
  logic [CNT_W-1:0] cnt;
  logic             resp_seen;
  logic             timeout_next;
  logic             valid_fall;
  logic             start;
  logic             in_flight;
  logic             timed_out;
  logic             resp_now;

  assign start     = (state == IDLE) && i_trainerror_en;
  assign in_flight = (state == SEND_REQ) || (state == WAIT_RESP);
  assign timed_out = in_flight && (cnt == CNT_LAST);
  assign resp_now  = (i_decoded_SB_msg == RESP_CODE);

  sb_valid_handshake u_valid_hs (
    .clk               (i_clk),
    .rst               (i_rst),
    .clear             (!i_trainerror_en),
    .start             (start),
    .active            (state == SEND_REQ),
    .busy              (i_SB_Busy),
    .falling_edge_busy (i_falling_edge_busy),
    .rx_valid          (i_rx_valid),
    .valid             (o_valid_tx),
    .valid_fall        (valid_fall)
  );

  always_ff @(posedge i_clk) begin
    if (i_rst)
      state <= IDLE;
    else
      state <= state_next;
  end

  always_comb begin
    state_next   = state;
    timeout_next = 1'b0;
    unique case (state)
      IDLE: begin
        if (i_trainerror_en)
          state_next = SEND_REQ;
      end
      SEND_REQ: begin
        // A resp that arrived while the req was still on the bus completes the handshake.
        if (valid_fall && (resp_seen || resp_now)) begin
          state_next = DONE;
        end else if (timed_out) begin
          state_next   = DONE;
          timeout_next = 1'b1;
        end else if (valid_fall) begin
          state_next = WAIT_RESP;
        end
      end
      WAIT_RESP: begin
        if (resp_now) begin
          state_next = DONE;
        end else if (timed_out) begin
          state_next   = DONE;
          timeout_next = 1'b1;
        end
      end
      DONE: begin
        timeout_next = o_timeout;
      end
      default: state_next = IDLE;
    endcase
    if (!i_trainerror_en) begin
      state_next   = IDLE;
      timeout_next = 1'b0;
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst || !i_trainerror_en) begin
      o_encoded_SB_msg_tx <= '0;
      o_trainerror_end_tx <= 1'b0;
      o_timeout           <= 1'b0;
      cnt                 <= '0;
      resp_seen           <= 1'b0;
    end else begin
      o_trainerror_end_tx <= (state_next == DONE);
      o_timeout           <= timeout_next;

      if (start) begin
        o_encoded_SB_msg_tx <= REQ_CODE;
        cnt                 <= '0;
      end else if (in_flight && (cnt != '1)) begin
        cnt <= cnt + 1'b1;
      end

      if ((state == SEND_REQ) && resp_now)
        resp_seen <= 1'b1;
      else if (state == IDLE)
        resp_seen <= 1'b0;
    end
  end

endmodule
